// File: rtl/cc_sched_pkg.sv
// Shared definitions for the coordinate-calculation job scheduler.
//   state_e : scheduler FSM states
//   MODE_*  : CC operating modes carried by each job
//   COORD_W : coordinate width, CNT_W : beat/timeout counter width
package cc_sched_pkg;

  localparam int COORD_W = 8;
  localparam int CNT_W   = 16;

  localparam logic [1:0] MODE_RASTER = 2'd0;
  localparam logic [1:0] MODE_CIRCLE = 2'd1;
  localparam logic [1:0] MODE_AREA   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    GAP    = 3'd4
  } state_e;

endpackage

// File: rtl/cc_job_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector, one bit per requester
//   en       : arbitration allowed this cycle
//   gnt      : one-hot grant (zero when en=0 or no request)
// The pointer holds the index just after the last grant; the search starts
// there and wraps. It only advances on an actual grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic       found;

  // Two passes with constant indices: first the requesters at or above the
  // pointer, then the ones below it, which gives the wrapped search order.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i >= int'(ptr_q))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
          ptr_d  = (i == NREQ - 1) ? 2'd0 : 2'(i + 1);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i < int'(ptr_q))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
          ptr_d  = (i == NREQ - 1) ? 2'd0 : 2'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cc_job_scheduler.sv
// Shares one coordinate-calculation (CC) engine between NREQ requesters.
//   req_*        : per-requester job (mode + four 8-bit points); req_ready is
//                  a one-cycle accept pulse
//   cc_*         : 4-beat load burst to CC and its variable-length result stream
//   rsp_*        : result beats tagged with requester id, last flag, beat count
//   err_timeout  : pulse when CC never answers within TIMEOUT cycles
//   err_mode     : pulse when a mode-3 job is rejected
//   busy         : scheduler not idle
//   dbg_state    : current FSM state
// Handshake: a job transfers in the cycle where req_valid[i] & req_ready[i];
// req_ready is only ever raised in IDLE for the single granted requester.
// Result beats have no backpressure: rsp_valid is a pure valid.
module cc_job_scheduler
  import cc_sched_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_mode,
  input  logic [32*NREQ-1:0]        req_x,
  input  logic [32*NREQ-1:0]        req_y,
  output logic                      cc_in_valid,
  output logic [1:0]                cc_mode,
  output logic [COORD_W-1:0]        cc_xi,
  output logic [COORD_W-1:0]        cc_yi,
  input  logic                      cc_out_valid,
  input  logic signed [COORD_W-1:0] cc_xo,
  input  logic signed [COORD_W-1:0] cc_yo,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_id,
  output logic [COORD_W-1:0]        rsp_x,
  output logic [COORD_W-1:0]        rsp_y,
  output logic                      rsp_last,
  output logic [CNT_W-1:0]          rsp_count,
  output logic                      err_timeout,
  output logic                      err_mode,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  state_e                   state_q, state_d;
  logic [1:0]               id_q, id_d;
  logic [1:0]               mode_q, mode_d;
  logic [1:0]               ld_idx_q, ld_idx_d;
  logic [4*COORD_W-1:0]     px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [COORD_W-1:0]       hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  logic                     err_mode_q, err_mode_d;
  logic                     err_timeout_q, err_timeout_d;

  logic [NREQ-1:0]          gnt;
  logic [1:0]               gnt_idx;
  logic [1:0]               sel_mode;
  logic [4*COORD_W-1:0]     sel_x, sel_y;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (state_q == IDLE),
    .gnt (gnt)
  );

  // Select the granted requester's job fields.
  always_comb begin
    gnt_idx  = '0;
    sel_mode = '0;
    sel_x    = '0;
    sel_y    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = 2'(i);
        sel_mode = req_mode[2*i +: 2];
        sel_x    = req_x[32*i +: 32];
        sel_y    = req_y[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    mode_d        = mode_q;
    ld_idx_d      = ld_idx_q;
    px_d          = px_q;
    py_d          = py_q;
    wait_cnt_d    = wait_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    hold_x_d      = hold_x_q;
    hold_y_d      = hold_y_q;
    err_mode_d    = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          id_d       = gnt_idx;
          mode_d     = sel_mode;
          px_d       = sel_x;
          py_d       = sel_y;
          ld_idx_d   = '0;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          if (sel_mode == MODE_RSVD) begin
            err_mode_d = 1'b1;
            state_d    = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        ld_idx_d = ld_idx_q + 2'd1;
        if (ld_idx_q == 2'd3) begin
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // A beat arriving on the last allowed cycle still wins over timeout.
        if (cc_out_valid) begin
          hold_x_d   = cc_xo;
          hold_y_d   = cc_yo;
          beat_cnt_d = CNT_W'(1);
          state_d    = STREAM;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      STREAM: begin
        // Output lags CC by one beat so the final beat can carry rsp_last
        // as soon as CC drops out_valid.
        if (cc_out_valid) begin
          hold_x_d = cc_xo;
          hold_y_d = cc_yo;
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= '0;
      mode_q        <= '0;
      ld_idx_q      <= '0;
      px_q          <= '0;
      py_q          <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      hold_x_q      <= '0;
      hold_y_q      <= '0;
      err_mode_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      mode_q        <= mode_d;
      ld_idx_q      <= ld_idx_d;
      px_q          <= px_d;
      py_q          <= py_d;
      wait_cnt_q    <= wait_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      hold_x_q      <= hold_x_d;
      hold_y_q      <= hold_y_d;
      err_mode_q    <= err_mode_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    req_ready   = gnt;
    cc_in_valid = (state_q == LOAD);
    cc_mode     = cc_in_valid ? mode_q : 2'd0;
    cc_xi       = cc_in_valid ? px_q[{ld_idx_q, 3'b000} +: COORD_W] : '0;
    cc_yi       = cc_in_valid ? py_q[{ld_idx_q, 3'b000} +: COORD_W] : '0;
    rsp_valid   = (state_q == STREAM);
    rsp_last    = rsp_valid && !cc_out_valid;
    rsp_x       = rsp_valid ? hold_x_q : '0;
    rsp_y       = rsp_valid ? hold_y_q : '0;
    rsp_count   = rsp_last ? beat_cnt_q : '0;
    rsp_id      = id_q;
    err_mode    = err_mode_q;
    err_timeout = err_timeout_q;
    busy        = (state_q != IDLE);
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_cc_job_scheduler.sv
// Bench for cc_job_scheduler: directed and random jobs, a CC stand-in that
// replays planned result beats, and a scoreboard of expected response beats.
module tb_cc_job_scheduler;

  localparam int NREQ       = 2;
  localparam int TIMEOUT    = 64;
  localparam int GAP_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [2*NREQ-1:0]  req_mode;
  logic [32*NREQ-1:0] req_x, req_y;
  logic               cc_in_valid, cc_out_valid;
  logic [1:0]         cc_mode;
  logic [7:0]         cc_xi, cc_yi, cc_xo, cc_yo;
  logic               rsp_valid, rsp_last, err_timeout, err_mode, busy;
  logic [1:0]         rsp_id;
  logic [7:0]         rsp_x, rsp_y;
  logic [15:0]        rsp_count;
  logic [2:0]         dbg_state;

  cc_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y),
    .cc_in_valid(cc_in_valid), .cc_mode(cc_mode), .cc_xi(cc_xi), .cc_yi(cc_yi),
    .cc_out_valid(cc_out_valid), .cc_xo(cc_xo), .cc_yo(cc_yo),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_last(rsp_last), .rsp_count(rsp_count),
    .err_timeout(err_timeout), .err_mode(err_mode), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];          // {id, x, y, last, count-if-last}
  logic [7:0]  beat_x[$], beat_y[$];
  int last_grant   = -1;
  int prev_grant_t = 0;
  int prev_min     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {4'h0, req_ready, cc_in_valid, cc_mode, cc_xi, cc_yi, rsp_valid, rsp_id,
            rsp_x, rsp_y, rsp_last, rsp_count, err_timeout, err_mode, busy};
  endfunction

  // Round-robin reference: first valid requester after the previous grant.
  function automatic int rr_pick(input logic [NREQ-1:0] v);
    int start;
    start = (last_grant + 1) % NREQ;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_job(input int r, input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
    req_mode[2*r +: 2] = m;
    req_x[32*r +: 32]  = x;
    req_y[32*r +: 32]  = y;
  endtask

  task automatic rand_job(input int r, input bit allow_rsvd);
    logic [1:0] m;
    m = 2'($urandom_range(0, 2));
    if (allow_rsvd && ($urandom_range(0, 7) == 0)) m = 2'd3;
    set_job(r, m, $urandom, $urandom);
  endtask

  task automatic fill_beats(input int n);
    beat_x.delete();
    beat_y.delete();
    repeat (n) begin
      beat_x.push_back(8'($urandom));
      beat_y.push_back(8'($urandom));
    end
  endtask

  // Beats the CC stand-in will return for whichever requester wins next.
  task automatic plan_beats(input logic [NREQ-1:0] v);
    int g;
    logic [1:0] m;
    g = rr_pick(v);
    m = req_mode[2*g +: 2];
    fill_beats((m == 2'd0) ? $urandom_range(2, 9) : 1);
  endtask

  task automatic noise();
    cc_out_valid = 1'($urandom_range(0, 1));
    cc_xo = 8'($urandom);
    cc_yo = 8'($urandom);
  endtask

  // One full job: grant, load burst, CC result replay, response checks.
  task automatic run_job(input logic [NREQ-1:0] valids, input bit hold, input int delay,
                         input int abort_after, output int g_obs);
    int g, n, t_g, popped, to_at, to_n, rsp_n;
    bit got, due;
    logic [1:0]  m;
    logic [31:0] xs, ys;
    logic [34:0] e, obs;
    g = rr_pick(valids);
    n = beat_x.size();
    g_obs = -1;
    popped = 0;
    req_valid = valids;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      noise();
      #1;
      if (req_ready != '0) got = 1'b1;
    end
    check("grant_seen", 64'(got), 64'd1);
    if (!got) begin
      req_valid = '0;
      return;
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_obs = i;
    check("grant_onehot", 64'(req_ready), 64'(1 << g));
    t_g = cyc;
    if (prev_min > 0) check("grant_spacing", 64'((t_g - prev_grant_t) >= prev_min), 64'd1);
    prev_grant_t = t_g;
    last_grant   = g;
    m  = req_mode[2*g +: 2];
    xs = req_x[32*g +: 32];
    ys = req_y[32*g +: 32];

    if (m == 2'd3) begin
      for (int c = 1; c <= GAP_CYCLES; c++) begin
        @(negedge clk);
        if (!hold && c == 1) req_valid = '0;
        noise();
        #1;
        check("rsvd_err_mode", 64'(err_mode), 64'(c == 1));
        check("rsvd_no_cc", 64'({cc_in_valid, rsp_valid, req_ready}), 64'd0);
        check("rsvd_busy", 64'(busy), 64'd1);
      end
      prev_min = 1 + GAP_CYCLES;
      return;
    end

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!hold && k == 0) req_valid = '0;
      noise();
      #1;
      check("load_beat", 64'({cc_in_valid, cc_mode, cc_xi, cc_yi}),
            64'({1'b1, m, xs[8*k +: 8], ys[8*k +: 8]}));
      check("load_quiet", 64'({req_ready, rsp_valid}), 64'd0);
    end

    if (n == 0) begin
      to_at = -1; to_n = 0; rsp_n = 0;
      for (int c = 0; c < TIMEOUT + GAP_CYCLES; c++) begin
        @(negedge clk);
        cc_out_valid = 1'b0;
        #1;
        if (err_timeout) begin to_n++; to_at = c; end
        if (rsp_valid) rsp_n++;
      end
      check("timeout_at", 64'(to_at), 64'(TIMEOUT));
      check("timeout_pulses", 64'(to_n), 64'd1);
      check("timeout_no_rsp", 64'(rsp_n), 64'd0);
      check("timeout_gap_busy", 64'(busy), 64'd1);
      prev_min = 5 + TIMEOUT + GAP_CYCLES;
      return;
    end

    for (int b = 0; b < n; b++)
      exp_q.push_back({2'(g), beat_x[b], beat_y[b], 1'(b == n - 1), (b == n - 1) ? 16'(n) : 16'h0});

    for (int c = 0; c <= delay + n + GAP_CYCLES; c++) begin
      @(negedge clk);
      if (c >= delay && c < delay + n) begin
        cc_out_valid = 1'b1;
        cc_xo = beat_x[c - delay];
        cc_yo = beat_y[c - delay];
      end else if (c > delay + n) begin
        noise();
      end else begin
        cc_out_valid = 1'b0;
        cc_xo = 8'($urandom);
        cc_yo = 8'($urandom);
      end
      #1;
      due = (c >= delay + 1) && (c <= delay + n);
      check("rsp_valid_timing", 64'(rsp_valid), 64'(due));
      check("ready_outside_idle", 64'(req_ready), 64'd0);
      if (c == 0) check("wait_cc_idle", 64'({cc_in_valid, cc_xi, cc_yi, busy}), 64'd1);
      if (c > delay + n) check("gap_state", 64'({busy, err_timeout, err_mode}), 64'b100);
      if (due && rsp_valid && exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        obs = {rsp_id, rsp_x, rsp_y, rsp_last, rsp_last ? rsp_count : 16'h0};
        check("rsp_beat", 64'(obs), 64'(e));
        popped++;
        if (abort_after >= 0 && popped == abort_after) begin
          #2 rst = 1'b1;
          #1;
          check("async_reset_outs", outs_vec(), 64'd0);
          exp_q.delete();
          cc_out_valid = 1'b0;
          prev_min = 0;
          return;
        end
      end
    end
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    prev_min = 6 + delay + n + GAP_CYCLES;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int g_obs;
    rst = 1'b1;
    req_valid = '0; req_mode = '0; req_x = '0; req_y = '0;
    cc_out_valid = 1'b0; cc_xo = '0; cc_yo = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", outs_vec(), 64'd0);
    rst = 1'b0;

    // Quadrilateral area job: single beat back.
    set_job(0, 2'd2, 32'h04000400, 32'h04040000);
    beat_x.delete(); beat_y.delete();
    beat_x.push_back(8'h00); beat_y.push_back(8'h10);
    run_job(2'b01, 1'b0, 0, -1, g_obs);
    check("area_grant", 64'(g_obs), 64'd0);

    // Raster job: 12 back-to-back beats.
    set_job(1, 2'd0, $urandom, $urandom);
    fill_beats(12);
    run_job(2'b10, 1'b0, 0, -1, g_obs);
    check("raster_grant", 64'(g_obs), 64'd1);

    // Both requesting continuously: strict alternation.
    for (int j = 0; j < 4; j++) begin
      rand_job(0, 1'b0);
      rand_job(1, 1'b0);
      plan_beats(2'b11);
      run_job(2'b11, 1'b1, $urandom_range(0, 3), -1, g_obs);
      check("rr_alternate", 64'(g_obs), 64'(j % 2));
    end
    req_valid = '0;

    // CC never answers.
    set_job(1, 2'd1, $urandom, $urandom);
    fill_beats(0);
    run_job(2'b10, 1'b0, 0, -1, g_obs);

    // Reserved mode rejected.
    set_job(0, 2'd3, $urandom, $urandom);
    fill_beats(1);
    run_job(2'b01, 1'b0, 0, -1, g_obs);
    check("rsvd_grant", 64'(g_obs), 64'd0);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      logic [NREQ-1:0] v;
      v = NREQ'($urandom_range(1, 3));
      rand_job(0, 1'b1);
      rand_job(1, 1'b1);
      plan_beats(v);
      run_job(v, 1'b0, $urandom_range(0, 4), -1, g_obs);
    end

    // Reset in the middle of a stream, then a clean job on requester 1.
    set_job(0, 2'd0, $urandom, $urandom);
    fill_beats(10);
    run_job(2'b01, 1'b0, 1, 5, g_obs);
    repeat (2) @(negedge clk);
    #1;
    check("reset_held_outs", outs_vec(), 64'd0);
    rst = 1'b0;
    last_grant = -1;
    set_job(1, 2'd2, $urandom, $urandom);
    fill_beats(1);
    run_job(2'b10, 1'b0, 0, -1, g_obs);
    check("post_reset_grant", 64'(g_obs), 64'd1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_job_scheduler.md
Name: cc_job_scheduler

Overview:
- Sequences the coordinate-calculation engine (CC: mode 0 trapezoid raster walk, mode 1 circle/line relation, mode 2 quadrilateral area) and shares it between NREQ requesters.
- Each requester presents one complete job in parallel: mode plus four 8-bit points.
- Round-robin arbitration picks a job, serialises its points into CC's 4-beat in_valid burst, then captures CC's variable-length out_valid stream.
- Returns the stream tagged with the requester id, with a last flag, a beat count, and timeout/error reporting.

Parameters:
- NREQ, 2, number of requesters (2..4)
- TIMEOUT, 64, max cycles in WAIT for the first cc_out_valid before abort
- GAP_CYCLES, 2, idle cycles forced between CC jobs so CC returns to IDLE

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset; CC's rst_n is driven from the inverse at top level
- req_valid  in  NREQ  job request per requester
- req_ready  out  NREQ  one-cycle accept pulse; a job transfers when valid&ready
- req_mode  in  2*NREQ  mode per requester, slice i = [2i+1:2i]
- req_x  in  32*NREQ  four x coords per requester; p0 in [7:0] ... p3 in [31:24] of each slice
- req_y  in  32*NREQ  four y coords, same packing
- cc_in_valid  out  1  CC in_valid
- cc_mode  out  2  CC mode
- cc_xi  out  8  CC xi
- cc_yi  out  8  CC yi
- cc_out_valid  in  1  CC out_valid
- cc_xo  in  8  CC xo (signed)
- cc_yo  in  8  CC yo (signed)
- rsp_valid  out  1  result beat valid; no backpressure
- rsp_id  out  2  requester index of the current job
- rsp_x  out  8  beat x
- rsp_y  out  8  beat y
- rsp_last  out  1  final beat of the job
- rsp_count  out  16  beats in the job, saturating at 16'hFFFF; valid when rsp_last=1
- err_timeout  out  1  one-cycle pulse on WAIT timeout
- err_mode  out  1  one-cycle pulse when a mode-3 job is rejected
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous and active-high: state IDLE, RR pointer 0, all outputs 0, holding register invalid. Reset mid-job abandons the job with no rsp and no error pulse.
- States are IDLE, LOAD, WAIT, STREAM, GAP.
- IDLE:
  - Arbitrate only here. Grant goes to the first requester with req_valid, starting from the index after the last grant, wrapping at NREQ.
  - The req_ready[g] pulse occurs in the grant cycle T; mode and points are latched into job registers.
  - If mode==3: pulse err_mode at T+1, no CC activity, go to GAP. Otherwise go to LOAD.
- LOAD:
  - cc_in_valid=1 for exactly 4 cycles, T+1..T+4, carrying p0,p1,p2,p3 in order.
  - cc_mode holds the job mode on all 4 beats.
  - cc_xi/cc_yi are 0 whenever cc_in_valid=0.
  - Next state is WAIT.
- WAIT:
  - A 16-bit counter runs from 0.
  - cc_out_valid=1 loads the beat into the holding register and moves to STREAM.
  - If the counter reaches TIMEOUT-1 with no beat: pulse err_timeout, emit no rsp, go to GAP.
- STREAM:
  - Each cycle with cc_out_valid=1, emit the held beat (rsp_valid=1, rsp_last=0) and load the new beat.
  - On the first cycle with cc_out_valid=0, emit the held beat with rsp_last=1 and rsp_count set, then go to GAP.
  - Response latency is exactly 1 cycle after the CC beat, with no gaps within a job.
- Beat counter: increments per captured beat and saturates. A mode 1/2 job yields exactly one beat, which carries rsp_last=1 and rsp_count=1.
- GAP: GAP_CYCLES cycles with no grant, then IDLE.
- Minimum grant-to-grant spacing is 4 + 1 + beats + 1 + GAP_CYCLES cycles.
- cc_out_valid in IDLE, LOAD or GAP is ignored and does not change state.
- rsp_id holds the granted index from grant until the next grant.
- Signed CC outputs are passed through bit-exact; there is no arithmetic on coordinates.
- A request whose req_valid drops before grant is simply not granted; there is no penalty.

Decomposition:
- Package cc_sched_pkg holds:
  - state enum {IDLE, LOAD, WAIT, STREAM, GAP}
  - MODE_RASTER=0, MODE_CIRCLE=1, MODE_AREA=2, MODE_RSVD=3
  - COORD_W=8, CNT_W=16
- Sub-module rr_arbiter (NREQ-wide request/enable/grant-onehot with internal pointer). It is instantiated once; everything else stays in the top.

Test Plan:
- Req0 mode 2, points (0,0),(4,0),(0,4),(4,4); CC model returns a single beat (0x00,0x10) → cc_in_valid high T+1..T+4 with xi 0,4,0,4. Exactly one rsp beat: x=0x00, y=0x10, last=1, count=1, id=0.
- Req1 mode 0 raster; CC model emits 12 consecutive beats → 12 rsp beats in order, each 1 cycle after its CC beat. Only the 12th has last=1, count=12.
- req_valid=2'b11 held for 4 jobs → grant order 0,1,0,1. req_ready never high outside IDLE; spacing is at least the minimum formula.
- CC model never asserts out_valid, TIMEOUT=64 → err_timeout pulses 64 cycles after entering WAIT, no rsp_valid, then GAP and the next grant proceeds.
- Req0 mode 3 → req_ready pulse, err_mode pulse, cc_in_valid stays 0, busy through GAP.
- Assert rst during STREAM after 5 beats → all outputs 0 on the asynchronous edge. After release, state is IDLE and a new job to req1 completes normally.
